// File: rtl/rr_lane_arbiter_64.sv
// rr_lane_arbiter_64
//   Round-robin arbiter sharing one downstream resource among 64 requesters.
//   A grant is held until the owner releases it, either with done or by
//   dropping its request. A hold watchdog forces release after MAX_HOLD
//   cycles. Every release is followed by at least one idle cycle.
// Ports:
//   clk       : system clock, rising edge
//   rst_n     : asynchronous active-low reset
//   req[63:0] : request vector, bit i = requester i
//   done      : owner release strobe, only looked at while a grant is active
//   gnt[63:0] : registered one-hot grant, zero when idle
//   gnt_idx   : binary index of the current or last winner
//   gnt_valid : high while a grant is active (equals |gnt)
//   timeout   : one-cycle pulse when the watchdog forces the release
module rr_lane_arbiter_64 #(
  parameter int N        = 64,
  parameter int IDXW     = 6,
  parameter int MAX_HOLD = 16,
  parameter int CW       = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic            done,
  output logic [N-1:0]    gnt,
  output logic [IDXW-1:0] gnt_idx,
  output logic            gnt_valid,
  output logic            timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

  state_t          state_q, state_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic [IDXW-1:0] gnt_idx_q, gnt_idx_d;
  logic            gnt_valid_q, gnt_valid_d;
  logic            timeout_q, timeout_d;
  logic [IDXW-1:0] ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  // Request vector rotated right by ptr, so bit 0 is the requester that
  // has the highest priority this round. Index arithmetic wraps in IDXW bits.
  logic [N-1:0] rot;
  for (genvar i = 0; i < N; i++) begin : g_rot
    assign rot[i] = req[IDXW'(i) + ptr_q];
  end

  // Lowest set bit of the rotated vector, encoded, then shifted back by ptr.
  logic [IDXW-1:0] off;
  logic [IDXW-1:0] win_idx;
  always_comb begin
    off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = IDXW'(i);
    end
    win_idx = off + ptr_q;
  end

  // Release conditions while granted.
  logic rel_done, rel_wd, rel_to, rel;
  assign rel_done = done;
  assign rel_wd   = ~req[gnt_idx_q];
  assign rel_to   = (cnt_q == HOLD_LAST);
  assign rel      = rel_done | rel_wd | rel_to;

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
    timeout_d   = 1'b0;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          gnt_d       = N'(1) << win_idx;
          gnt_idx_d   = win_idx;
          gnt_valid_d = 1'b1;
          ptr_d       = win_idx + IDXW'(1);
          cnt_d       = '0;
          state_d     = GRANT;
        end
      end
      GRANT: begin
        if (rel) begin
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
          state_d     = IDLE;
          // Watchdog only claims the release when nothing else caused it.
          timeout_d   = rel_to & ~rel_done & ~rel_wd;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      ptr_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = gnt_valid_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_lane_arbiter_64.sv
// Directed bench for rr_lane_arbiter_64. Expected outputs are queued as each
// step's stimulus is driven and popped/compared after the following edge.
module tb_rr_lane_arbiter_64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] req;
  logic        done;
  logic [63:0] gnt;
  logic [5:0]  gnt_idx;
  logic        gnt_valid;
  logic        timeout;

  rr_lane_arbiter_64 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .done     (done),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx),
    .gnt_valid(gnt_valid),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] g;
    logic [5:0]  idx;
    logic        v;
    logic        to;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic logic [63:0] bit_of(input int i);
    logic [63:0] one;
    one = 64'd1;
    return one << i;
  endfunction

  // Queue an expectation: granted (v=1) to idx, or idle holding idx.
  task automatic push_exp(input int idx, input bit v, input bit to);
    exp_t e;
    e.g   = v ? bit_of(idx) : 64'd0;
    e.idx = 6'(idx);
    e.v   = v;
    e.to  = to;
    sb.push_back(e);
  endtask

  task automatic chk(input string tag);
    exp_t e;
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty, observed gnt=%h idx=%0d", tag, gnt, gnt_idx);
    end else begin
      e = sb.pop_front();
      assert ({gnt, gnt_idx, gnt_valid, timeout} === {e.g, e.idx, e.v, e.to})
      else begin
        n_fail++;
        $display("FAIL %s: observed gnt=%h idx=%0d v=%b to=%b expected gnt=%h idx=%0d v=%b to=%b",
                 tag, gnt, gnt_idx, gnt_valid, timeout, e.g, e.idx, e.v, e.to);
        $error("%s mismatch", tag);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = '0;
    done  = 1'b0;
    #2;
    push_exp(0, 0, 0); chk("reset_state");
    #10 rst_n = 1'b1;

    // Single requester 5
    tick();
    req = bit_of(5);
    push_exp(5, 1, 0); tick(); chk("single_grant");
    push_exp(5, 1, 0); tick(); chk("single_hold");
    done = 1'b1;
    push_exp(5, 0, 0); tick(); chk("single_release");
    done = 1'b0;
    push_exp(5, 1, 0); tick(); chk("single_regrant_after_gap");

    // Async reset mid-grant, between edges
    #2 rst_n = 1'b0;
    #1;
    push_exp(0, 0, 0); chk("async_reset_drop");
    req = bit_of(3) | bit_of(60);
    #1 rst_n = 1'b1;
    push_exp(3, 1, 0); tick(); chk("post_reset_ptr0");
    req = '0;
    push_exp(3, 0, 0); tick(); chk("post_reset_withdraw");

    // Round robin from ptr=0 after a fresh reset
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    req = '1;
    for (int i = 0; i <= 64; i++) begin
      push_exp(i % 64, 1, 0); tick(); chk($sformatf("rr_grant_%0d", i));
      done = 1'b1;
      push_exp(i % 64, 0, 0); tick(); chk($sformatf("rr_release_%0d", i));
      done = 1'b0;
    end

    // Wrap: park ptr at 63 via a grant to 62
    req = bit_of(62);
    push_exp(62, 1, 0); tick(); chk("wrap_setup_62");
    req = bit_of(63) | bit_of(0);
    push_exp(62, 0, 0); tick(); chk("wrap_setup_release");
    push_exp(63, 1, 0); tick(); chk("wrap_grant_63");
    done = 1'b1;
    push_exp(63, 0, 0); tick(); chk("wrap_release_63");
    done = 1'b0;
    push_exp(0, 1, 0); tick(); chk("wrap_grant_0");
    done = 1'b1;
    req  = bit_of(0) | bit_of(1);
    push_exp(0, 0, 0); tick(); chk("wrap_release_0");
    done = 1'b0;
    push_exp(1, 1, 0); tick(); chk("wrap_ptr_back_to_1");
    done = 1'b1;
    push_exp(1, 0, 0); tick(); chk("wrap_release_1");
    done = 1'b0;

    // Watchdog timeout on requester 10
    req = bit_of(10);
    push_exp(10, 1, 0); tick(); chk("to_grant");
    for (int k = 1; k <= 15; k++) begin
      push_exp(10, 1, 0); tick(); chk($sformatf("to_hold_%0d", k));
    end
    push_exp(10, 0, 1); tick(); chk("to_forced_release");
    push_exp(10, 1, 0); tick(); chk("to_regrant");

    // Owner 10 withdraws in favour of 7
    req = bit_of(7);
    push_exp(10, 0, 0); tick(); chk("wd_release_10");
    push_exp(7, 1, 0); tick(); chk("wd_grant_7");
    req = bit_of(7) | bit_of(3);
    push_exp(7, 1, 0); tick(); chk("nonowner_change_ignored");
    req = bit_of(3);
    push_exp(7, 0, 0); tick(); chk("wd_release_7");
    push_exp(3, 1, 0); tick(); chk("wd_grant_3");

    // done coincides with the last hold cycle
    for (int k = 1; k <= 15; k++) begin
      push_exp(3, 1, 0); tick(); chk($sformatf("co_hold_%0d", k));
    end
    done = 1'b1;
    push_exp(3, 0, 0); tick(); chk("co_release_no_timeout");

    // done in IDLE is ignored
    req = '0;
    push_exp(3, 0, 0); tick(); chk("idle_done_ignored");
    done = 1'b0;
    push_exp(3, 0, 0); tick(); chk("idle_stays");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
